ddram_arbiter: RTL

// - Shares the single 64-bit DDRAM Avalon-style port between two clients:

---
 rtl/ddram_arb_pkg.sv | 7 +
 rtl/ddram_arb_rr.sv | 8 +
 rtl/ddram_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ddram_arb_pkg.sv
// ddram_arb_pkg: shared types and widths for the two-client DDRAM port arbiter
package ddram_arb_pkg;
  localparam int AW = 29;
  localparam int BW = 8;
  typedef enum logic [1:0] {IDLE, WR, RDCMD, RDDATA} state_t;
  typedef enum logic [1:0] {OWN_C0, OWN_C1, OWN_NONE} owner_t;
endpackage

// File: rtl/ddram_arb_rr.sv
// ddram_arb_rr: two-way round-robin select; with no or both requests the client not served last wins
module ddram_arb_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       sel
);
  assign sel = (req == 2'b01) ? 1'b0 : (req == 2'b10) ? 1'b1 : ~last_grant;
endmodule

// File: rtl/ddram_arbiter.sv
// ddram_arbiter: shares one 64-bit DDRAM port between a cache/ROM client and a bulk client,
// one registered transaction at a time, steering read beats back to the issuing client.
module ddram_arbiter
  import ddram_arb_pkg::*;
(
  input  logic          DDRAM_CLK,
  input  logic          reset_n,
  input  logic          DDRAM_BUSY,
  output logic [BW-1:0] DDRAM_BURSTCNT,
  output logic [AW-1:0] DDRAM_ADDR,
  input  logic [63:0]   DDRAM_DOUT,
  input  logic          DDRAM_DOUT_READY,
  output logic          DDRAM_RD,
  output logic [63:0]   DDRAM_DIN,
  output logic [7:0]    DDRAM_BE,
  output logic          DDRAM_WE,
  input  logic [AW-1:0] c0_addr,
  input  logic [BW-1:0] c0_burstcnt,
  input  logic          c0_rd,
  input  logic          c0_we,
  input  logic [63:0]   c0_din,
  input  logic [7:0]    c0_be,
  output logic          c0_busy,
  output logic [63:0]   c0_dout,
  output logic          c0_dout_ready,
  input  logic [AW-1:0] c1_addr,
  input  logic [BW-1:0] c1_burstcnt,
  input  logic          c1_rd,
  input  logic          c1_we,
  input  logic [63:0]   c1_din,
  input  logic [7:0]    c1_be,
  output logic          c1_busy,
  output logic [63:0]   c1_dout,
  output logic          c1_dout_ready
);
  state_t        state;
  owner_t        owner;
  logic          last_grant;
  logic [BW-1:0] cnt;
  logic [1:0]    req;
  logic          sel, sel_we, accept, beat_ok;
  logic [AW-1:0] sel_addr;
  logic [BW-1:0] sel_burst;
  logic [63:0]   sel_din;
  logic [7:0]    sel_be;

  assign req = {c1_rd | c1_we, c0_rd | c0_we};

  ddram_arb_rr u_rr (.req(req), .last_grant(last_grant), .sel(sel));

  always_comb begin
    sel_we    = sel ? c1_we : c0_we;
    sel_addr  = sel ? c1_addr : c0_addr;
    sel_burst = sel ? c1_burstcnt : c0_burstcnt;
    sel_din   = sel ? c1_din : c0_din;
    sel_be    = sel ? c1_be : c0_be;
    accept    = (state == IDLE) && req[sel];
    // a beat coinciding with the controller taking the read command is already data
    beat_ok   = DDRAM_DOUT_READY && ((state == RDDATA) || ((state == RDCMD) && !DDRAM_BUSY));
  end

  assign c0_busy       = ~(reset_n && (state == IDLE) && !sel);
  assign c1_busy       = ~(reset_n && (state == IDLE) && sel);
  assign c0_dout       = DDRAM_DOUT;
  assign c1_dout       = DDRAM_DOUT;
  assign c0_dout_ready = beat_ok && (owner == OWN_C0);
  assign c1_dout_ready = beat_ok && (owner == OWN_C1);

  always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      owner          <= OWN_NONE;
      last_grant     <= 1'b1;
      cnt            <= '0;
      DDRAM_RD       <= 1'b0;
      DDRAM_WE       <= 1'b0;
      DDRAM_BURSTCNT <= BW'(1);
      DDRAM_ADDR     <= '0;
      DDRAM_DIN      <= '0;
      DDRAM_BE       <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          DDRAM_ADDR <= sel_addr;
          DDRAM_DIN  <= sel_din;
          DDRAM_BE   <= sel_be;
          owner      <= sel ? OWN_C1 : OWN_C0;
          if (sel_we) begin
            DDRAM_BURSTCNT <= BW'(1);
            DDRAM_WE       <= 1'b1;
            state          <= WR;
          end else begin
            DDRAM_BURSTCNT <= (sel_burst == '0) ? BW'(1) : sel_burst;
            DDRAM_RD       <= 1'b1;
            state          <= RDCMD;
          end
        end
        WR: if (!DDRAM_BUSY) begin
          DDRAM_WE   <= 1'b0;
          last_grant <= (owner == OWN_C1);
          owner      <= OWN_NONE;
          state      <= IDLE;
        end
        RDCMD: if (!DDRAM_BUSY) begin
          DDRAM_RD <= 1'b0;
          if (DDRAM_DOUT_READY && (DDRAM_BURSTCNT == BW'(1))) begin
            last_grant <= (owner == OWN_C1);
            owner      <= OWN_NONE;
            state      <= IDLE;
          end else begin
            cnt   <= DDRAM_BURSTCNT - BW'(DDRAM_DOUT_READY);
            state <= RDDATA;
          end
        end
        RDDATA: if (DDRAM_DOUT_READY) begin
          if (cnt == BW'(1)) begin
            last_grant <= (owner == OWN_C1);
            owner      <= OWN_NONE;
            state      <= IDLE;
          end else begin
            cnt <= cnt - BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
